// File: rtl/plc_acc_stack.sv
// Accumulator stack: PUSH/POP/ADD/SUB/CLRS on a 2**DEPTH_LOG deep word stack with sticky
// overflow/underflow errors. Define ACC_STACK_DUP_EN to add the DUP (110) operation.
module plc_acc_stack #(
    parameter int DW_W      = 32,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic [2:0]           OP,
    input  logic                 OP_VLD,
    output logic                 OP_RDY,
    input  logic [DW_W-1:0]      ACC_I,
    input  logic                 ERR_ACK,
    output logic [DW_W-1:0]      RES_O,
    output logic                 RES_VLD,
    output logic                 CARRY_O,
    output logic                 ZERO_O,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic [DEPTH_LOG:0]   LEVEL,
    output logic                 OVF_ERR,
    output logic                 UNF_ERR
);

    localparam int DEPTH = 2 ** DEPTH_LOG;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_CLRS = 3'b101;
`ifdef ACC_STACK_DUP_EN
    localparam logic [2:0] OP_DUP  = 3'b110;
`endif

    localparam logic [DEPTH_LOG:0]   LVL_ZERO = '0;
    localparam logic [DEPTH_LOG:0]   LVL_ONE  = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG:0]   LVL_FULL = {1'b1, {DEPTH_LOG{1'b0}}};
    localparam logic [DEPTH_LOG-1:0] ADDR_ONE = {{(DEPTH_LOG-1){1'b0}}, 1'b1};

    typedef enum logic {ST_RUN, ST_ERR} state_t;

    state_t state_reg, state_next;

    logic [DW_W-1:0]      mem [0:DEPTH-1];
    logic [DEPTH_LOG:0]   level_reg, level_next;
    logic [DW_W-1:0]      res_reg, res_next;
    logic                 res_vld_reg, res_vld_next;
    logic                 carry_reg, carry_next;
    logic                 zero_reg, zero_next;
    logic                 ovf_reg, ovf_next;
    logic                 unf_reg, unf_next;

    logic                 run;
    logic                 full_w, empty_w;
    logic                 err_set;
    logic                 mem_we;
    logic [DW_W-1:0]      mem_wdata;
    logic [DEPTH_LOG-1:0] wr_addr, top_addr;
    logic [DW_W-1:0]      top_word;
    logic [DW_W:0]        sum_w, diff_w;

    assign run      = (state_reg == ST_RUN);
    assign full_w   = (level_reg == LVL_FULL);
    assign empty_w  = (level_reg == LVL_ZERO);
    assign wr_addr  = level_reg[DEPTH_LOG-1:0];
    // When full the low bits wrap to 0, so 0 - 1 still lands on the last entry.
    assign top_addr = level_reg[DEPTH_LOG-1:0] - ADDR_ONE;
    assign top_word = mem[top_addr];
    assign sum_w    = {1'b0, top_word} + {1'b0, ACC_I};
    assign diff_w   = {1'b0, top_word} - {1'b0, ACC_I};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state_reg <= ST_RUN;
        else     state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:  if (err_set) state_next = ST_ERR;
            ST_ERR:  if (ERR_ACK) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        OP_RDY = (state_reg == ST_RUN);
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        level_next   = level_reg;
        res_next     = res_reg;
        res_vld_next = 1'b0;
        carry_next   = carry_reg;
        zero_next    = zero_reg;
        ovf_next     = ovf_reg;
        unf_next     = unf_reg;
        err_set      = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = ACC_I;

        if (!run) begin
            if (ERR_ACK) begin
                ovf_next = 1'b0;
                unf_next = 1'b0;
            end
        end else if (OP_VLD) begin
            case (OP)
                OP_PUSH: begin
                    if (full_w) begin
                        ovf_next = 1'b1;
                        err_set  = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        level_next = level_reg + LVL_ONE;
                    end
                end
                OP_POP, OP_ADD, OP_SUB: begin
                    if (empty_w) begin
                        unf_next = 1'b1;
                        err_set  = 1'b1;
                    end else begin
                        level_next   = level_reg - LVL_ONE;
                        res_vld_next = 1'b1;
                        if (OP == OP_POP) begin
                            res_next = top_word;
                        end else if (OP == OP_ADD) begin
                            res_next   = sum_w[DW_W-1:0];
                            carry_next = sum_w[DW_W];
                            zero_next  = (sum_w[DW_W-1:0] == '0);
                        end else begin
                            res_next   = diff_w[DW_W-1:0];
                            carry_next = diff_w[DW_W];
                            zero_next  = (diff_w[DW_W-1:0] == '0);
                        end
                    end
                end
                OP_CLRS: level_next = LVL_ZERO;
`ifdef ACC_STACK_DUP_EN
                OP_DUP: begin
                    if (empty_w) begin
                        unf_next = 1'b1;
                        err_set  = 1'b1;
                    end else if (full_w) begin
                        ovf_next = 1'b1;
                        err_set  = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        mem_wdata  = top_word;
                        level_next = level_reg + LVL_ONE;
                    end
                end
`endif
                OP_NOP:  ;
                default: ;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            level_reg   <= LVL_ZERO;
            res_reg     <= '0;
            res_vld_reg <= 1'b0;
            carry_reg   <= 1'b0;
            zero_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
        end else begin
            level_reg   <= level_next;
            res_reg     <= res_next;
            res_vld_reg <= res_vld_next;
            carry_reg   <= carry_next;
            zero_reg    <= zero_next;
            ovf_reg     <= ovf_next;
            unf_reg     <= unf_next;
        end
    end

    // Stack storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[wr_addr] <= mem_wdata;
    end

    assign RES_O   = res_reg;
    assign RES_VLD = res_vld_reg;
    assign CARRY_O = carry_reg;
    assign ZERO_O  = zero_reg;
    assign FULL    = full_w;
    assign EMPTY   = empty_w;
    assign LEVEL   = level_reg;
    assign OVF_ERR = ovf_reg;
    assign UNF_ERR = unf_reg;

endmodule

// File: tb/tb_plc_acc_stack.sv
// Directed bench for plc_acc_stack; DUP expectations follow ACC_STACK_DUP_EN.
module tb_plc_acc_stack;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_CLRS = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [2:0]  OP;
    logic        OP_VLD;
    logic        OP_RDY;
    logic [31:0] ACC_I;
    logic        ERR_ACK;
    logic [31:0] RES_O;
    logic        RES_VLD;
    logic        CARRY_O;
    logic        ZERO_O;
    logic        FULL;
    logic        EMPTY;
    logic [4:0]  LEVEL;
    logic        OVF_ERR;
    logic        UNF_ERR;

    int total = 0;
    int bad   = 0;

    plc_acc_stack #(.DW_W(32), .DEPTH_LOG(4)) dut (
        .CLK(CLK), .CLR(CLR), .OP(OP), .OP_VLD(OP_VLD), .OP_RDY(OP_RDY),
        .ACC_I(ACC_I), .ERR_ACK(ERR_ACK), .RES_O(RES_O), .RES_VLD(RES_VLD),
        .CARRY_O(CARRY_O), .ZERO_O(ZERO_O), .FULL(FULL), .EMPTY(EMPTY),
        .LEVEL(LEVEL), .OVF_ERR(OVF_ERR), .UNF_ERR(UNF_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One operation presented for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] acc);
        @(negedge CLK);
        OP = op; ACC_I = acc; OP_VLD = 1'b1;
        @(negedge CLK);
        OP_VLD = 1'b0; OP = OP_NOP;
        $display("op=%0d acc=%0h -> level=%0d res=%0h vld=%0b c=%0b z=%0b ovf=%0b unf=%0b rdy=%0b",
                 op, acc, LEVEL, RES_O, RES_VLD, CARRY_O, ZERO_O, OVF_ERR, UNF_ERR, OP_RDY);
    endtask

    task automatic ack();
        @(negedge CLK);
        ERR_ACK = 1'b1;
        @(negedge CLK);
        ERR_ACK = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; OP = OP_NOP; OP_VLD = 1'b0; ACC_I = '0; ERR_ACK = 1'b0;
        #1;
        chk("rst_level", 32'(LEVEL), 32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_full",  32'(FULL),  32'd0);
        chk("rst_res",   RES_O,      32'd0);
        chk("rst_flags", {28'd0, RES_VLD, CARRY_O, ZERO_O, OVF_ERR | UNF_ERR}, 32'd0);
        chk("rst_rdy",   32'(OP_RDY), 32'd1);
        @(negedge CLK);
        CLR = 1'b0;

        // basic push/pop
        issue(OP_PUSH, 32'd5);
        issue(OP_PUSH, 32'd7);
        chk("push_level", 32'(LEVEL), 32'd2);
        chk("push_novld", 32'(RES_VLD), 32'd0);
        issue(OP_POP, 32'd0);
        chk("pop_res",   RES_O, 32'd7);
        chk("pop_vld",   32'(RES_VLD), 32'd1);
        chk("pop_level", 32'(LEVEL), 32'd1);
        @(negedge CLK);
        chk("pop_vld_pulse", 32'(RES_VLD), 32'd0);
        issue(OP_POP, 32'd0);
        chk("pop2_res",   RES_O, 32'd5);
        chk("pop2_empty", 32'(EMPTY), 32'd1);

        // ADD with carry-out
        issue(OP_PUSH, 32'hFFFF_FFFF);
        issue(OP_ADD, 32'd1);
        chk("add_res",   RES_O, 32'd0);
        chk("add_cz",    {30'd0, CARRY_O, ZERO_O}, 32'd3);
        chk("add_empty", 32'(EMPTY), 32'd1);
        chk("add_vld",   32'(RES_VLD), 32'd1);

        // SUB with borrow, SUB equal, plain ADD
        issue(OP_PUSH, 32'd3);
        issue(OP_SUB, 32'd5);
        chk("sub_res", RES_O, 32'hFFFF_FFFE);
        chk("sub_cz",  {30'd0, CARRY_O, ZERO_O}, 32'd2);
        issue(OP_PUSH, 32'd5);
        issue(OP_SUB, 32'd5);
        chk("sub_eq_res", RES_O, 32'd0);
        chk("sub_eq_cz",  {30'd0, CARRY_O, ZERO_O}, 32'd1);
        issue(OP_PUSH, 32'd10);
        issue(OP_ADD, 32'd20);
        chk("add2_res", RES_O, 32'd30);
        chk("add2_cz",  {30'd0, CARRY_O, ZERO_O}, 32'd0);

        // NOP / reserved / CLRS
        issue(OP_PUSH, 32'd1);
        issue(OP_NOP, 32'd99);
        chk("nop_level", 32'(LEVEL), 32'd1);
        chk("nop_vld",   32'(RES_VLD), 32'd0);
        issue(OP_RSV, 32'd99);
        chk("rsv_level", 32'(LEVEL), 32'd1);
        chk("rsv_res",   RES_O, 32'd30);
        issue(OP_CLRS, 32'd0);
        chk("clrs_level", 32'(LEVEL), 32'd0);
        chk("clrs_res",   RES_O, 32'd30);
        chk("clrs_vld",   32'(RES_VLD), 32'd0);

        // DUP
        issue(OP_PUSH, 32'd9);
        issue(OP_DUP, 32'd0);
`ifdef ACC_STACK_DUP_EN
        chk("dup_level", 32'(LEVEL), 32'd2);
        issue(OP_POP, 32'd0);
        chk("dup_pop1", RES_O, 32'd9);
`else
        chk("dup_level", 32'(LEVEL), 32'd1);
`endif
        issue(OP_POP, 32'd0);
        chk("dup_pop2",  RES_O, 32'd9);
        chk("dup_empty", 32'(EMPTY), 32'd1);

        // fill to full, then overflow
        for (int i = 0; i < 16; i++) issue(OP_PUSH, 32'(i * 3 + 1));
        chk("full_flag",  32'(FULL), 32'd1);
        chk("full_level", 32'(LEVEL), 32'd16);
        issue(OP_PUSH, 32'hDEAD);
        chk("ovf_err",   32'(OVF_ERR), 32'd1);
        chk("ovf_rdy",   32'(OP_RDY), 32'd0);
        chk("ovf_level", 32'(LEVEL), 32'd16);
        issue(OP_POP, 32'd0);
        chk("err_ignore_level", 32'(LEVEL), 32'd16);
        chk("err_ignore_vld",   32'(RES_VLD), 32'd0);
        ack();
        chk("ack_rdy",   32'(OP_RDY), 32'd1);
        chk("ack_ovf",   32'(OVF_ERR), 32'd0);
        chk("ack_level", 32'(LEVEL), 32'd16);
        issue(OP_POP, 32'd0);
        chk("full_top", RES_O, 32'd46);
        issue(OP_CLRS, 32'd0);

        // underflow
        issue(OP_POP, 32'd0);
        chk("unf_err", 32'(UNF_ERR), 32'd1);
        chk("unf_vld", 32'(RES_VLD), 32'd0);
        chk("unf_res", RES_O, 32'd46);
        chk("unf_rdy", 32'(OP_RDY), 32'd0);
        ack();
        chk("unf_ack", 32'(UNF_ERR), 32'd0);

        // asynchronous CLR with a POP in flight
        issue(OP_PUSH, 32'd1);
        issue(OP_PUSH, 32'd2);
        issue(OP_PUSH, 32'd3);
        @(negedge CLK);
        OP = OP_POP; OP_VLD = 1'b1;
        #2 CLR = 1'b1;
        #1;
        chk("aclr_level", 32'(LEVEL), 32'd0);
        chk("aclr_empty", 32'(EMPTY), 32'd1);
        chk("aclr_res",   RES_O, 32'd0);
        @(negedge CLK);
        OP_VLD = 1'b0; OP = OP_NOP; CLR = 1'b0;
        @(negedge CLK);
        chk("aclr_novld", 32'(RES_VLD), 32'd0);

        // error flag cleared by CLR, first op taken on first edge after release
        issue(OP_ADD, 32'd4);
        chk("add_unf", 32'(UNF_ERR), 32'd1);
        chk("add_unf_carry", 32'(CARRY_O), 32'd0);
        @(negedge CLK);
        #2 CLR = 1'b1;
        #1;
        chk("aclr_unf", 32'(UNF_ERR), 32'd0);
        chk("aclr_rdy", 32'(OP_RDY), 32'd1);
        @(negedge CLK);
        CLR = 1'b0; OP = OP_PUSH; ACC_I = 32'd42; OP_VLD = 1'b1;
        @(negedge CLK);
        OP_VLD = 1'b0; OP = OP_NOP;
        chk("first_op_level", 32'(LEVEL), 32'd1);
        issue(OP_POP, 32'd0);
        chk("first_op_res", RES_O, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
